// File: rtl/fb_port_a_ctrl.sv
// Port A sequencer for the 1-bit frame buffer: arbitrates CPU pixel accesses
// against a whole-frame fill engine (clear, set, checkerboard, invert).
//   state    | meaning
//   IDLE     | serve CPU requests, wait for FILL_START
//   FILL     | write one constant/checker pixel per cycle
//   INV_RD   | issue read of the pixel to invert
//   INV_WAIT | BRAM read latency
//   INV_WR   | write back the inverted pixel
//   DONE     | pulse FILL_DONE, drop FILL_BUSY
module fb_port_a_ctrl #(
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 7,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CPU_REQ,
    input  logic                  CPU_WE,
    input  logic [X_WIDTH-1:0]    CPU_X,
    input  logic [Y_WIDTH-1:0]    CPU_Y,
    input  logic                  CPU_DATA,
    output logic                  CPU_ACK,
    output logic                  CPU_RDATA,
    output logic                  CPU_RVALID,
    input  logic                  FILL_START,
    input  logic [1:0]            FILL_MODE,
    output logic                  FILL_BUSY,
    output logic                  FILL_DONE,
    output logic [ADDR_WIDTH-1:0] FB_ADDR,
    output logic                  FB_DATA_IN,
    output logic                  FB_WE,
    input  logic                  FB_DATA_OUT
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_INV_RD,
        ST_INV_WAIT,
        ST_INV_WR,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            mode_q, mode_d;
    logic                  start_pend_q, start_pend_d;
    logic                  din_q, din_d;
    logic                  we_q, we_d;
    logic                  ack_q, ack_d;
    logic                  rd1_q, rd1_d;
    logic                  rd2_q, rd2_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cpu_grant;
    logic                  fill_val;
    logic                  cnt_last;
    logic [1:0]            start_mode;

    assign cnt_last = (cnt_q == {ADDR_WIDTH{1'b1}});

    always_comb begin
        case (mode_q)
            2'b01:   fill_val = 1'b1;
            2'b10:   fill_val = cnt_q[0] ^ cnt_q[X_WIDTH];
            default: fill_val = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        mode_d       = mode_q;
        start_pend_d = 1'b0;
        din_d        = din_q;
        we_d         = 1'b0;
        ack_d        = 1'b0;
        rd1_d        = 1'b0;
        rd2_d        = rd1_q;
        // Read data is sampled two edges after the grant, independent of state.
        rvalid_d     = rd2_q;
        rdata_d      = rd2_q ? FB_DATA_OUT : rdata_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cpu_grant    = 1'b0;
        start_mode   = start_pend_q ? mode_q : FILL_MODE;

        case (state_q)
            ST_IDLE: begin
                if (CPU_REQ && !start_pend_q) begin
                    cpu_grant = 1'b1;
                    if (FILL_START) begin
                        mode_d       = FILL_MODE;
                        start_pend_d = 1'b1;
                    end
                end else if (FILL_START || start_pend_q) begin
                    mode_d  = start_mode;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (start_mode == 2'b11) ? ST_INV_RD : ST_FILL;
                end
            end
            ST_FILL: begin
                if (CPU_REQ) begin
                    cpu_grant = 1'b1;
                end else begin
                    addr_d = cnt_q;
                    we_d   = 1'b1;
                    din_d  = fill_val;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_last) state_d = ST_DONE;
                end
            end
            ST_INV_RD: begin
                if (CPU_REQ) begin
                    cpu_grant = 1'b1;
                end else begin
                    addr_d  = cnt_q;
                    state_d = ST_INV_WAIT;
                end
            end
            ST_INV_WAIT: state_d = ST_INV_WR;
            ST_INV_WR: begin
                addr_d  = cnt_q;
                we_d    = 1'b1;
                din_d   = ~FB_DATA_OUT;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_last ? ST_DONE : ST_INV_RD;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (cpu_grant) begin
            addr_d = {CPU_Y, CPU_X};
            we_d   = CPU_WE;
            din_d  = CPU_WE ? CPU_DATA : din_q;
            ack_d  = 1'b1;
            rd1_d  = ~CPU_WE;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            mode_q       <= 2'b00;
            start_pend_q <= 1'b0;
            din_q        <= 1'b0;
            we_q         <= 1'b0;
            ack_q        <= 1'b0;
            rd1_q        <= 1'b0;
            rd2_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            mode_q       <= mode_d;
            start_pend_q <= start_pend_d;
            din_q        <= din_d;
            we_q         <= we_d;
            ack_q        <= ack_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign CPU_ACK    = ack_q;
    assign CPU_RDATA  = rdata_q;
    assign CPU_RVALID = rvalid_q;
    assign FILL_BUSY  = busy_q;
    assign FILL_DONE  = done_q;
    assign FB_ADDR    = addr_q;
    assign FB_DATA_IN = din_q;
    assign FB_WE      = we_q;

endmodule

// File: tb/tb_fb_port_a_ctrl.sv
// Bench for fb_port_a_ctrl with a behavioural BRAM on port A. A reduced
// 32x16 frame keeps whole-frame sweeps short; the address math is parameterised.
module tb_fb_port_a_ctrl;

    localparam int XW   = 5;
    localparam int YW   = 4;
    localparam int AW   = XW + YW;
    localparam int NPIX = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_data;
    logic [XW-1:0] cpu_x;
    logic [YW-1:0] cpu_y;
    logic          cpu_ack, cpu_rdata, cpu_rvalid;
    logic          fill_start;
    logic [1:0]    fill_mode;
    logic          fill_busy, fill_done;
    logic [AW-1:0] fb_addr;
    logic          fb_din, fb_we;
    bit            fb_dout;
    bit            mem [NPIX];

    int tests = 0;
    int fails = 0;
    bit exp_q[$];

    fb_port_a_ctrl #(.X_WIDTH(XW), .Y_WIDTH(YW), .ADDR_WIDTH(AW)) dut (
        .CLK(clk), .RESET(rst),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_X(cpu_x), .CPU_Y(cpu_y),
        .CPU_DATA(cpu_data), .CPU_ACK(cpu_ack), .CPU_RDATA(cpu_rdata),
        .CPU_RVALID(cpu_rvalid), .FILL_START(fill_start), .FILL_MODE(fill_mode),
        .FILL_BUSY(fill_busy), .FILL_DONE(fill_done), .FB_ADDR(fb_addr),
        .FB_DATA_IN(fb_din), .FB_WE(fb_we), .FB_DATA_OUT(fb_dout)
    );

    always #5 clk = ~clk;

    // Read-first synchronous BRAM, one cycle latency.
    always @(posedge clk) begin
        fb_dout <= mem[fb_addr];
        if (fb_we === 1'b1) mem[fb_addr] <= fb_din;
    end

    function automatic logic [15:0] outs();
        return {cpu_ack, cpu_rdata, cpu_rvalid, fill_busy, fill_done, fb_addr, fb_din, fb_we};
    endfunction

    // kind: 0 all-0, 1 all-1, 2 checker; sp_addr < 0 disables the exception pixel.
    function automatic int mem_errors(input int kind, input int sp_addr, input bit sp_val);
        int errs = 0;
        bit e;
        for (int a = 0; a < NPIX; a++) begin
            if (kind == 2) e = bit'(((a >> 0) ^ (a >> XW)) & 1);
            else e = (kind == 1);
            if (a == sp_addr) e = sp_val;
            if (mem[a] !== e) errs++;
        end
        return errs;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input bit w, input int x, input int y, input bit d, output int wait_n);
        cpu_we   = w;
        cpu_x    = x[XW-1:0];
        cpu_y    = y[YW-1:0];
        cpu_data = d;
        cpu_req  = 1'b1;
        wait_n   = 0;
        do begin
            tick();
            wait_n++;
        end while (cpu_ack !== 1'b1 && wait_n < 20);
        cpu_req = 1'b0;
    endtask

    task automatic do_read(input int x, input int y, input bit e);
        int w, lat;
        bit exp_v;
        logic [AW-1:0] a;
        a = AW'(y * (1 << XW) + x);
        exp_q.push_back(e);
        cpu_access(1'b0, x, y, 1'b0, w);
        tests++;
        if (w !== 1 || cpu_ack !== 1'b1 || fb_we !== 1'b0 || fb_addr !== a) begin
            fails++;
            $display("FAIL read_issue: wait=%0d ack=%b we=%b addr=%0d, want wait=1 ack=1 we=0 addr=%0d",
                     w, cpu_ack, fb_we, fb_addr, a);
        end
        lat = 0;
        do begin
            tick();
            lat++;
        end while (cpu_rvalid !== 1'b1 && lat < 10);
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL read_latency: rvalid after %0d edges, want 2", lat);
        end
        exp_v = exp_q.pop_front();
        tests++;
        if (cpu_rdata !== exp_v) begin
            fails++;
            $display("FAIL read_data addr %0d: got %b want %b", a, cpu_rdata, exp_v);
        end
    endtask

    // Runs one fill; optional CPU access raised after sample cpu_at (0 = same edge as FILL_START).
    // dur counts edges spent sequencing pixels (start edge and DONE edge excluded).
    task automatic run_fill(input bit [1:0] mode, input int cpu_at, input bit cw, input int cx,
                            input int cy, input bit cd, output int dur, output int ack_wait);
        int n, ack_n;
        bit chk_next, exp_v;
        logic [AW-1:0] last_wr, cpu_addr;
        cpu_addr = AW'(cy * (1 << XW) + cx);
        dur = -1; ack_wait = -1; ack_n = -1; chk_next = 1'b0; last_wr = '0;
        fill_mode = mode;
        fill_start = 1'b1;
        if (cpu_at == 0) begin
            cpu_we = cw; cpu_x = cx[XW-1:0]; cpu_y = cy[YW-1:0]; cpu_data = cd; cpu_req = 1'b1;
        end
        tick();
        fill_start = 1'b0;
        if (cpu_at == 0) begin
            tests++;
            if (cpu_ack !== 1'b1 || fill_busy !== 1'b0 || fb_addr !== cpu_addr) begin
                fails++;
                $display("FAIL same_edge_grant: ack=%b busy=%b addr=%0d, want ack=1 busy=0 addr=%0d",
                         cpu_ack, fill_busy, fb_addr, cpu_addr);
            end
            ack_wait = 0;
            cpu_req = 1'b0;
            tick();
        end
        tests++;
        if (fill_busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_set: busy=%b want 1", fill_busy);
        end
        n = 0;
        while (n < 4 * NPIX + 16) begin
            tick();
            n++;
            if (n == 1) begin
                tests++;
                if (fb_addr !== '0) begin
                    fails++;
                    $display("FAIL first_pixel_addr: got %0d want 0", fb_addr);
                end
            end
            if (n == 10) begin
                fill_start = 1'b1;
                fill_mode  = ~mode;
            end else if (n == 11) begin
                fill_start = 1'b0;
                fill_mode  = mode;
            end
            if (chk_next) begin
                chk_next = 1'b0;
                tests++;
                if (fb_addr !== last_wr + 1'b1) begin
                    fails++;
                    $display("FAIL counter_hold: next fill addr %0d want %0d", fb_addr, last_wr + 1'b1);
                end
            end
            if (cpu_ack === 1'b1) begin
                ack_n = n;
                ack_wait = n - cpu_at;
                cpu_req = 1'b0;
                chk_next = 1'b1;
                tests++;
                if (fb_addr !== cpu_addr || fb_we !== cw || (cw && fb_din !== cd)) begin
                    fails++;
                    $display("FAIL cpu_slot: addr=%0d we=%b din=%b want addr=%0d we=%b din=%b",
                             fb_addr, fb_we, fb_din, cpu_addr, cw, cd);
                end
            end else if (fb_we === 1'b1) begin
                last_wr = fb_addr;
            end
            if (cpu_rvalid === 1'b1) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : ~cpu_rdata;
                tests++;
                if (n - ack_n !== 2 || cpu_rdata !== exp_v) begin
                    fails++;
                    $display("FAIL read_in_fill: rvalid %0d edges after ack, data %b, want 2 edges data %b",
                             n - ack_n, cpu_rdata, exp_v);
                end
            end
            if (fill_done === 1'b1) begin
                tests++;
                if (fill_busy !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_clear: busy=%b at FILL_DONE, want 0", fill_busy);
                end
                dur = n - 1;
                break;
            end
            if (n == cpu_at) begin
                cpu_we = cw; cpu_x = cx[XW-1:0]; cpu_y = cy[YW-1:0]; cpu_data = cd; cpu_req = 1'b1;
                if (!cw) exp_q.push_back(cd);
            end
        end
        cpu_req = 1'b0;
        if (dur < 0) begin
            tests++;
            fails++;
            $display("FAIL fill_timeout: no FILL_DONE within %0d cycles", n);
        end
        tick();
        tests++;
        if (fill_done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: FILL_DONE still %b, want 0", fill_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_data = 1'b0; cpu_x = '0; cpu_y = '0;
        fill_start = 1'b0; fill_mode = 2'b00;
        tick();
        tick();
        tests++;
        if (outs() !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", outs());
        end
        rst = 1'b0;
        tick();
        tick();
        tests++;
        if (outs() !== 16'h0) begin
            fails++;
            $display("FAIL idle_outputs: got %h want 0", outs());
        end
    endtask

    task automatic test_cpu_rw();
        int w;
        cpu_access(1'b1, 15, 0, 1'b1, w);
        tests++;
        if (w !== 1) begin
            fails++;
            $display("FAIL write_ack_latency: %0d edges want 1", w);
        end
        tests++;
        if (fb_addr !== AW'(15) || fb_we !== 1'b1 || fb_din !== 1'b1) begin
            fails++;
            $display("FAIL write_port: addr=%0d we=%b din=%b want 15 1 1", fb_addr, fb_we, fb_din);
        end
        tick();
        tests++;
        if (cpu_ack !== 1'b0 || fb_we !== 1'b0 || fb_addr !== AW'(15)) begin
            fails++;
            $display("FAIL ack_pulse: ack=%b we=%b addr=%0d want 0 0 15", cpu_ack, fb_we, fb_addr);
        end
        do_read(15, 0, 1'b1);
        tick();
        tick();
        tick();
        tests++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 1'b1) begin
            fails++;
            $display("FAIL rdata_hold: rvalid=%b rdata=%b want 0 1", cpu_rvalid, cpu_rdata);
        end
        do_read(16, 0, 1'b0);
    endtask

    task automatic test_fill_checker();
        int dur, aw_n, errs;
        run_fill(2'b10, 0, 1'b1, 1, 0, 1'b0, dur, aw_n);
        tests++;
        if (dur !== NPIX) begin
            fails++;
            $display("FAIL checker_duration: %0d want %0d", dur, NPIX);
        end
        errs = mem_errors(2, -1, 1'b0);
        tests++;
        if (errs !== 0) begin
            fails++;
            $display("FAIL checker_image: %0d wrong pixels want 0", errs);
        end
        do_read(0, 0, 1'b0);
        do_read(1, 0, 1'b1);
        do_read(0, 1, 1'b1);
        do_read(1, 1, 1'b0);
    endtask

    task automatic test_fill_invert();
        int dur, aw_n, errs;
        run_fill(2'b01, -1, 1'b0, 0, 0, 1'b0, dur, aw_n);
        errs = mem_errors(1, -1, 1'b0);
        tests++;
        if (dur !== NPIX || errs !== 0) begin
            fails++;
            $display("FAIL set_fill: duration %0d errors %0d want %0d and 0", dur, errs, NPIX);
        end
        run_fill(2'b11, 50, 1'b0, 16, 12, 1'b1, dur, aw_n);
        tests++;
        if (dur !== 3 * NPIX + 1) begin
            fails++;
            $display("FAIL invert_duration: %0d want %0d", dur, 3 * NPIX + 1);
        end
        tests++;
        if (aw_n < 1 || aw_n > 3) begin
            fails++;
            $display("FAIL invert_ack_wait: %0d edges want 1..3", aw_n);
        end
        errs = mem_errors(0, -1, 1'b0);
        tests++;
        if (errs !== 0) begin
            fails++;
            $display("FAIL invert_image: %0d wrong pixels want 0", errs);
        end
        do_read(0, 0, 1'b0);
        do_read(8, 9, 1'b0);
    endtask

    task automatic test_cpu_mid_fill();
        int dur, aw_n, errs;
        // The write lands at addr 296 after the sweep has passed it, so it survives.
        run_fill(2'b00, 400, 1'b1, 8, 9, 1'b1, dur, aw_n);
        tests++;
        if (dur !== NPIX + 1) begin
            fails++;
            $display("FAIL mid_fill_duration: %0d want %0d", dur, NPIX + 1);
        end
        tests++;
        if (aw_n < 1 || aw_n > 3) begin
            fails++;
            $display("FAIL mid_fill_ack_wait: %0d edges want 1..3", aw_n);
        end
        errs = mem_errors(0, 296, 1'b1);
        tests++;
        if (errs !== 0) begin
            fails++;
            $display("FAIL clear_image: %0d wrong pixels want 0", errs);
        end
        do_read(8, 9, 1'b1);
    endtask

    task automatic test_reset_mid_fill();
        int dur, aw_n, errs, bad;
        fill_mode = 2'b01;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (100) tick();
        #3 rst = 1'b1;
        #1;
        tests++;
        if (outs() !== 16'h0) begin
            fails++;
            $display("FAIL async_reset: outputs %h want 0", outs());
        end
        tick();
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (fill_busy !== 1'b0 || fill_done !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL abort_quiet: %0d cycles with busy/done set, want 0", bad);
        end
        tests++;
        if (mem[50] !== 1'b1 || mem[400] !== 1'b0) begin
            fails++;
            $display("FAIL abort_image: mem[50]=%b mem[400]=%b want 1 0", mem[50], mem[400]);
        end
        run_fill(2'b01, -1, 1'b0, 0, 0, 1'b0, dur, aw_n);
        errs = mem_errors(1, -1, 1'b0);
        tests++;
        if (dur !== NPIX || errs !== 0) begin
            fails++;
            $display("FAIL restart_fill: duration %0d errors %0d want %0d and 0", dur, errs, NPIX);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_rw();
        test_fill_checker();
        test_fill_invert();
        test_cpu_mid_fill();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
